// File: rtl/vm_vend_ctrl.sv
// Vending machine transaction controller: accumulates coin credit, vends a selection,
// then pays change back one coin at a time, largest coin first.
module vm_vend_ctrl #(
    parameter int unsigned CREDIT_W   = 8,
    parameter int unsigned CREDIT_MAX = 200
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_coin_valid,
    input  logic [1:0]          i_coin_val,
    input  logic                i_sel_valid,
    input  logic [CREDIT_W-1:0] i_sel_price,
    input  logic                i_cancel,
    input  logic                i_vend_ack,
    input  logic                i_change_ack,
    output logic [CREDIT_W-1:0] o_credit,
    output logic                o_busy,
    output logic                o_vend_req,
    output logic                o_change_req,
    output logic [1:0]          o_change_coin,
    output logic                o_coin_reject,
    output logic                o_insufficient
);

    typedef enum logic [1:0] {StIdle, StCredit, StVend, StChange} state_e;

    state_e              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic                r_busy;
    logic                r_vend_req;
    logic                r_change_req;
    logic [1:0]          r_change_coin;
    logic                r_coin_reject;
    logic                r_insufficient;

    logic [CREDIT_W:0]   w_coin_units;
    logic [CREDIT_W:0]   w_credit_sum;
    logic                w_coin_fits;
    logic [CREDIT_W-1:0] w_change_units;
    logic [CREDIT_W-1:0] w_credit_left;
    logic                w_sel_live;

    // Greedy change: 50 sen while at least 5 units remain, then 20 sen, then 10 sen.
    function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] c);
        if (c >= CREDIT_W'(5)) return 2'd2;
        if (c >= CREDIT_W'(2)) return 2'd1;
        return 2'd0;
    endfunction

    always_comb begin
        w_coin_units = '0;
        unique case (i_coin_val)
            2'd0: w_coin_units = (CREDIT_W+1)'(1);
            2'd1: w_coin_units = (CREDIT_W+1)'(2);
            2'd2: w_coin_units = (CREDIT_W+1)'(5);
            2'd3: w_coin_units = (CREDIT_W+1)'(10);
        endcase
        w_credit_sum = {1'b0, r_credit} + w_coin_units;
        w_coin_fits  = (w_credit_sum <= (CREDIT_W+1)'(CREDIT_MAX));

        w_change_units = CREDIT_W'(1);
        if (r_change_coin == 2'd2) w_change_units = CREDIT_W'(5);
        else if (r_change_coin == 2'd1) w_change_units = CREDIT_W'(2);
        // Greedy coin never exceeds the remaining credit, so this cannot underflow.
        w_credit_left = r_credit - w_change_units;

        w_sel_live = i_sel_valid && (i_sel_price != '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= StIdle;
            r_credit       <= '0;
            r_busy         <= 1'b0;
            r_vend_req     <= 1'b0;
            r_change_req   <= 1'b0;
            r_change_coin  <= 2'd0;
            r_coin_reject  <= 1'b0;
            r_insufficient <= 1'b0;
        end else begin
            r_coin_reject  <= 1'b0;
            r_insufficient <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_coin_valid) begin
                        if (w_coin_fits) begin
                            r_credit <= w_credit_sum[CREDIT_W-1:0];
                            r_state  <= StCredit;
                        end else begin
                            r_coin_reject <= 1'b1;
                        end
                    end
                end
                StCredit: begin
                    // Priority: cancel, then a live selection, then the coin.
                    if (i_cancel) begin
                        r_coin_reject <= i_coin_valid;
                        if (r_credit == '0) begin
                            r_state <= StIdle;
                        end else begin
                            r_state       <= StChange;
                            r_busy        <= 1'b1;
                            r_change_req  <= 1'b1;
                            r_change_coin <= greedy_coin(r_credit);
                        end
                    end else if (w_sel_live) begin
                        r_coin_reject <= i_coin_valid;
                        if (i_sel_price > r_credit) begin
                            r_insufficient <= 1'b1;
                        end else begin
                            r_credit   <= r_credit - i_sel_price;
                            r_state    <= StVend;
                            r_busy     <= 1'b1;
                            r_vend_req <= 1'b1;
                        end
                    end else if (i_coin_valid) begin
                        if (w_coin_fits) r_credit <= w_credit_sum[CREDIT_W-1:0];
                        else r_coin_reject <= 1'b1;
                    end
                end
                StVend: begin
                    r_coin_reject <= i_coin_valid;
                    if (i_vend_ack) begin
                        r_vend_req <= 1'b0;
                        if (r_credit != '0) begin
                            r_state       <= StChange;
                            r_change_req  <= 1'b1;
                            r_change_coin <= greedy_coin(r_credit);
                        end else begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                StChange: begin
                    r_coin_reject <= i_coin_valid;
                    if (i_change_ack) begin
                        r_credit <= w_credit_left;
                        if (w_credit_left != '0) begin
                            r_change_coin <= greedy_coin(w_credit_left);
                        end else begin
                            r_state       <= StIdle;
                            r_busy        <= 1'b0;
                            r_change_req  <= 1'b0;
                            r_change_coin <= 2'd0;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_credit       = r_credit;
    assign o_busy         = r_busy;
    assign o_vend_req     = r_vend_req;
    assign o_change_req   = r_change_req;
    assign o_change_coin  = r_change_coin;
    assign o_coin_reject  = r_coin_reject;
    assign o_insufficient = r_insufficient;

endmodule

// File: tb/tb_vm_vend_ctrl.sv
// Bench for vm_vend_ctrl: directed scenarios with literal expectations, then random
// stimulus, all checked every cycle against a credit/change-list model.
module tb_vm_vend_ctrl;

    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          coin_valid = 1'b0;
    logic [1:0]    coin_val = 2'd0;
    logic          sel_valid = 1'b0;
    logic [CW-1:0] sel_price = '0;
    logic          cancel = 1'b0;
    logic          vend_ack = 1'b0;
    logic          change_ack = 1'b0;
    logic [CW-1:0] credit;
    logic          busy;
    logic          vend_req;
    logic          change_req;
    logic [1:0]    change_coin;
    logic          coin_reject;
    logic          insufficient;

    int n_cmp = 0;
    int n_fail = 0;

    vm_vend_ctrl #(.CREDIT_W(CW), .CREDIT_MAX(200)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_coin_valid(coin_valid),
        .i_coin_val(coin_val),
        .i_sel_valid(sel_valid),
        .i_sel_price(sel_price),
        .i_cancel(cancel),
        .i_vend_ack(vend_ack),
        .i_change_ack(change_ack),
        .o_credit(credit),
        .o_busy(busy),
        .o_vend_req(vend_req),
        .o_change_req(change_req),
        .o_change_coin(change_coin),
        .o_coin_reject(coin_reject),
        .o_insufficient(insufficient)
    );

    always #5 clk = ~clk;

    // Model: credit as an integer, a vend-pending flag, and the list of change coins
    // still owed (greedy breakdown of the credit when the refund starts).
    bit m_valid = 1'b0;
    int m_credit = 0;
    bit m_vending = 1'b0;
    int m_q[$];
    bit m_rej = 1'b0;
    bit m_ins = 1'b0;

    function automatic int units_of(input int code);
        return (code == 3) ? 10 : (code == 2) ? 5 : (code == 1) ? 2 : 1;
    endfunction

    task automatic fill_change();
        int c;
        c = m_credit;
        m_q.delete();
        repeat (c / 5) m_q.push_back(2);
        c = c % 5;
        repeat (c / 2) m_q.push_back(1);
        if (c % 2 == 1) m_q.push_back(0);
    endtask

    initial forever begin
        @(posedge clk);
        m_rej = 1'b0;
        m_ins = 1'b0;
        if (rst) begin
            m_valid   = 1'b1;
            m_credit  = 0;
            m_vending = 1'b0;
            m_q.delete();
        end else if (m_vending) begin
            m_rej = coin_valid;
            if (vend_ack) begin
                m_vending = 1'b0;
                if (m_credit > 0) fill_change();
            end
        end else if (m_q.size() > 0) begin
            m_rej = coin_valid;
            if (change_ack) begin
                m_credit = m_credit - units_of(m_q[0]);
                void'(m_q.pop_front());
            end
        end else if (m_credit > 0) begin
            if (cancel) begin
                m_rej = coin_valid;
                fill_change();
            end else if (sel_valid && sel_price != 0) begin
                m_rej = coin_valid;
                if (int'(sel_price) > m_credit) begin
                    m_ins = 1'b1;
                end else begin
                    m_credit  = m_credit - int'(sel_price);
                    m_vending = 1'b1;
                end
            end else if (coin_valid) begin
                if (m_credit + units_of(int'(coin_val)) <= 200)
                    m_credit = m_credit + units_of(int'(coin_val));
                else
                    m_rej = 1'b1;
            end
        end else if (coin_valid) begin
            m_credit = units_of(int'(coin_val));
        end
    end

    initial forever begin
        logic [15:0] act;
        logic [15:0] exp;
        bit          creq;
        @(negedge clk);
        if (m_valid) begin
            creq = (m_q.size() > 0);
            exp = {CW'(m_credit), m_vending || creq, m_vending, creq,
                   creq ? 2'(m_q[0]) : 2'd0, m_rej, m_ins};
            act = {credit, busy, vend_req, change_req,
                   creq ? change_coin : 2'd0, coin_reject, insufficient};
            n_cmp++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t got %h expected %h", $time, act, exp);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs right after a falling edge; returns at the next falling edge.
    task automatic apply(input bit cv, input int cval, input bit sv, input int price,
                         input bit cn, input bit va, input bit ca);
        coin_valid = cv;
        coin_val   = 2'(cval);
        sel_valid  = sv;
        sel_price  = CW'(price);
        cancel     = cn;
        vend_ack   = va;
        change_ack = ca;
        @(negedge clk);
        coin_valid = 1'b0;
        sel_valid  = 1'b0;
        cancel     = 1'b0;
        vend_ack   = 1'b0;
        change_ack = 1'b0;
    endtask

    task automatic coin(input int code);
        apply(1'b1, code, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        apply(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_credit", 32'(credit), 0);
        chk("reset_flags", 32'({busy, vend_req, change_req, change_coin, coin_reject,
                                insufficient}), 0);
        rst = 1'b0;

        // RM1 + 50 sen, buy at 12, get 20 sen + 10 sen back.
        coin(3);
        chk("s1_credit10", 32'(credit), 10);
        coin(2);
        chk("s1_credit15", 32'(credit), 15);
        apply(1'b0, 0, 1'b1, 12, 1'b0, 1'b0, 1'b0);
        chk("s1_after_sel", 32'(credit), 3);
        chk("s1_vend_req", 32'({vend_req, busy}), 3);
        idle();
        chk("s1_vend_hold", 32'(vend_req), 1);
        apply(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("s1_chg1", 32'({vend_req, change_req, change_coin}), 32'b0_1_01);
        apply(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("s1_chg2", 32'({credit, change_req, change_coin}), {8'd1, 3'b1_00});
        apply(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("s1_done", 32'({credit, change_req, busy}), 0);

        // Insufficient credit.
        coin(2);
        apply(1'b0, 0, 1'b1, 8, 1'b0, 1'b0, 1'b0);
        chk("s2_insuff", 32'({credit, insufficient, vend_req}), {8'd5, 2'b10});
        idle();
        chk("s2_pulse_end", 32'(insufficient), 0);
        apply(1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("s2_refund", 32'({change_req, change_coin}), 3'b1_10);
        apply(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("s2_done", 32'({credit, change_req}), 0);

        // Fill to the credit ceiling, overflow coin rejected, refund as 40 x 50 sen.
        repeat (20) coin(3);
        chk("s3_full", 32'(credit), 200);
        coin(0);
        chk("s3_overflow", 32'({credit, coin_reject}), {8'd200, 1'b1});
        apply(1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            chk("s3_coin50", 32'({change_req, change_coin}), 3'b1_10);
            apply(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        end
        chk("s3_done", 32'({credit, change_req, busy}), 0);

        // Coin during a long vend is rejected; exact price goes straight back to idle.
        coin(3);
        apply(1'b0, 0, 1'b1, 10, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                coin(1);
                chk("s4_reject", 32'({coin_reject, vend_req, credit}), {2'b11, 8'd0});
            end else begin
                idle();
            end
        end
        chk("s4_hold", 32'(vend_req), 1);
        apply(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("s4_idle", 32'({vend_req, busy, change_req, credit}), 0);

        // Cancel + select + coin together with credit 7: refund wins.
        coin(2);
        coin(1);
        chk("s5_credit7", 32'(credit), 7);
        apply(1'b1, 3, 1'b1, 3, 1'b1, 1'b0, 1'b0);
        chk("s5_refund", 32'({change_req, change_coin, coin_reject, vend_req}), 5'b1_10_1_0);
        apply(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("s5_chg2", 32'({credit, change_coin}), {8'd2, 2'd1});
        apply(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("s5_done", 32'({credit, change_req}), 0);

        // Reset in the middle of a refund.
        coin(3);
        apply(1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("s6_in_change", 32'(change_req), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("s6_reset", 32'({change_req, credit, busy}), 0);
        rst = 1'b0;

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(999) == 0);
            apply($urandom_range(99) < 30, int'($urandom_range(3)),
                  $urandom_range(99) < 12, int'($urandom_range(40)),
                  $urandom_range(99) < 3, $urandom_range(99) < 20,
                  $urandom_range(99) < 30);
        end
        rst = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vm_vend_ctrl.md
Name: vm_vend_ctrl

Overview:
- Transaction controller for the vending machine. Accumulates coin credit and accepts an item selection with its price.
- Sequences the product dispenser, then returns change one coin at a time through the change dispenser.
- Sits between the coin validator / keypad front end and the dispenser actuators. Supports cancel/refund.

Parameters:
- CREDIT_W, 8, width of credit and price, in 10-sen units.
- CREDIT_MAX, 200, maximum credit held (RM20.00).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- coin_valid  in  1  one-cycle pulse: validated coin present.
- coin_val  in  2  coin value code: 0=10 sen, 1=20 sen, 2=50 sen, 3=RM1. Credit added is 1, 2, 5, 10 units respectively.
- sel_valid  in  1  one-cycle pulse: item selected.
- sel_price  in  CREDIT_W  price of the selected item.
- cancel  in  1  one-cycle pulse: refund request.
- vend_ack  in  1  product dispenser done; one-cycle pulse.
- change_ack  in  1  change dispenser ejected one coin; one-cycle pulse.
- credit  out  CREDIT_W  current credit (display).
- busy  out  1  high in VEND or CHANGE.
- vend_req  out  1  dispense-product request (level).
- change_req  out  1  eject-one-coin request (level).
- change_coin  out  2  coin to eject: 0=10 sen, 1=20 sen, 2=50 sen.
- coin_reject  out  1  one-cycle pulse: coin not credited; front end returns it.
- insufficient  out  1  one-cycle pulse: selection refused, credit below price.

Behaviour:
- Reset: state IDLE, credit=0. All outputs 0. A reset in any state aborts the transaction, drops vend_req/change_req next edge, and discards credit.
- Registered outputs. All responses appear the cycle after the input edge.
- States and transitions:
  - IDLE: credit==0. coin_valid -> add coin, go to CREDIT.
  - CREDIT: accepts coins.
    - coin_valid: if credit+value <= CREDIT_MAX, add it; otherwise pulse coin_reject and leave credit unchanged.
    - sel_valid with sel_price==0: ignored.
    - sel_valid with sel_price > credit: pulse insufficient, stay.
    - sel_valid with sel_price <= credit: credit -= sel_price, go to VEND.
    - cancel: go to CHANGE, or IDLE if credit==0.
  - VEND: vend_req=1, held until vend_ack. On vend_ack: vend_req=0, go to CHANGE if credit>0, else IDLE.
  - CHANGE: greedy, largest coin first. change_coin=2 if credit>=5, else 1 if credit>=2, else 0. change_req=1 held.
    - On change_ack: credit -= coin value (5/2/1). Recompute change_coin. Stay in CHANGE while credit>0, else change_req=0 and go to IDLE.
    - change_coin is stable while change_req is high.
- Coins arriving in VEND or CHANGE: coin_reject pulse, not credited. sel_valid and cancel are ignored in VEND and CHANGE.
- Simultaneous events in CREDIT, priority cancel > sel_valid > coin_valid:
  - cancel with coin: coin rejected.
  - sel_valid with coin: coin rejected, selection evaluated against current credit. Applies whether the selection is accepted or refused.
- Credit arithmetic uses CREDIT_W+1 bits internally for the overflow compare. Credit never wraps and never goes negative.
- Acks with no request outstanding are ignored.
- Latency:
  - Exact-price vend: sel_valid -> vend_req 1 cycle; vend_ack -> IDLE 1 cycle.
  - Each change coin: change_ack -> next change_coin valid 1 cycle.

Test Plan:
- Reset, then insert RM1 (coin_val=3) and 50 sen (2); select price 12 -> credit shows 10, then 15; after selection credit=3, vend_req=1. vend_ack -> change sequence: coin 1 (20 sen) then coin 0 (10 sen); credit ends 0, state IDLE.
- Credit 5; select price 8 -> insufficient pulse for 1 cycle, credit stays 5, vend_req stays 0.
- Insert RM1 x20 (credit 200), then 10 sen -> coin_reject pulse, credit remains 200. Cancel -> 40 change coins of code 2, credit reaches 0.
- In VEND, hold vend_ack low 10 cycles and insert a coin -> vend_req stays 1, coin_reject pulses, credit unchanged.
- Same cycle: cancel, sel_valid and coin_valid with credit 7 -> refund path taken (coins 2 then 1), coin rejected, no vend_req.
- Assert rst mid-CHANGE with change_req=1 -> next cycle change_req=0, credit=0, busy=0, IDLE.
